pingpong_stage_ctrl: RTL and testbench
======================================

# pingpong_stage_ctrl

Sequencing controller for one two-buffer ping-pong channel between a producer process and a consumer process in the streaming FFT dataflow. It launches the producer whenever the channel has a free buffer and commits the filled buffer with a push. It launches the consumer whenever a filled buffer is available and releases it with a pop. It counts a programmed number of blocks per job and reports completion.

## Interface
Parameters:
- CntWidth, 16, width of block counters and cfg_num_blocks

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  job start; sampled only while idle (busy=0)
- cfg_num_blocks  in  CntWidth  blocks per job; latched when start is accepted
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job completion
- err  out  1  sticky protocol error; cleared on accepted start
- blocks_written  out  CntWidth  blocks committed this job
- blocks_read  out  CntWidth  blocks released this job
- prod_start  out  1  producer run request; level, held until prod_done
- prod_done  in  1  producer finished current block (1-cycle pulse)
- cons_start  out  1  consumer run request; level, held until cons_done
- cons_done  in  1  consumer finished current block (1-cycle pulse)
- buf_full_n  in  1  channel has a free write buffer
- buf_empty_n  in  1  channel has a filled read buffer
- buf_i_ce, buf_i_write  out  1 each  push strobe to channel (both driven identically)
- buf_t_ce, buf_t_read  out  1 each  pop strobe to channel (both driven identically)

## Operation
- Top FSM states are IDLE, RUN and FIN.
  - IDLE: on start=1, latch num=cfg_num_blocks, clear counters and err, then go to RUN.
  - RUN: exit to FIN once blocks_read==num and both sub-FSMs are idle.
  - FIN: done=1 for exactly one cycle, then go to IDLE.
- busy=1 in RUN and FIN.
- Producer FSM states are P_IDLE, P_WAIT, P_RUN, P_COMMIT and P_HOLD.
  - P_IDLE: when top FSM is in RUN and blocks_written<num, go to P_WAIT.
  - P_WAIT: when buf_full_n=1, go to P_RUN.
  - P_RUN: prod_start=1. When prod_done=1, go to P_COMMIT.
  - P_COMMIT: buf_i_ce=buf_i_write=1 for one cycle; blocks_written+1; go to P_HOLD.
  - P_HOLD: one settle cycle so the channel's registered full_n reflects the push. Then go to P_WAIT if blocks_written<num, otherwise P_IDLE.
- Consumer FSM states are C_IDLE, C_WAIT, C_RUN, C_REL and C_HOLD. It mirrors the producer FSM, with these substitutions:
  - buf_empty_n replaces buf_full_n.
  - cons_start/cons_done replace prod_start/prod_done.
  - The C_REL strobe drives buf_t_ce=buf_t_read=1 and increments blocks_read.
  - It is gated by blocks_read<num.
- All outputs are registered or decoded from state only; no input reaches an output combinationally.
- Counters do not wrap, because num bounds them. cfg_num_blocks=0 gives a job with no launches: RUN→FIN immediately.
- Simultaneous P_COMMIT and C_REL in the same cycle is legal; push and pop are independent.
- A start with busy=1 is ignored, with no effect on num or counters.
- err is set by any of:
  - prod_done=1 while the producer FSM is not in P_RUN;
  - cons_done=1 while the consumer FSM is not in C_RUN;
  - buf_full_n=0 in P_COMMIT;
  - buf_empty_n=0 in C_REL.
- A spurious done pulse is otherwise ignored: no commit and no count.
- Reset assertion mid-job aborts immediately. Every FSM and counter returns to its reset state, and the channel must be reset by the same reset.

## Timing
- Reset values:
  - busy, done, err, prod_start, cons_start and all buf_* strobes = 0;
  - blocks_written = blocks_read = 0;
  - all FSMs in their IDLE state.
- Start to first launch: start sampled at edge k → busy=1 after k → P_WAIT after k+1 → prod_start=1 after k+2, given buf_full_n=1.
- Producer cycle per block: P_WAIT (≥1) + P_RUN (until prod_done sampled) + 1 commit + 1 hold.
  - prod_start falls on the edge that samples prod_done.
  - The push strobe is high the following cycle.
- Consumer launch: first cons_start appears 2 cycles after the push strobe. The channel's empty_n rises one cycle after the push, and C_WAIT samples it.
- Completion: done pulses 2 cycles after the last C_REL strobe (C_HOLD, then FIN). busy falls the cycle after done.
- num=0: done pulses in the cycle after busy rises; busy is high for 2 cycles total.

## Test plan
- Nominal job: num=3, producer and consumer each answer done 4 cycles after start.
  - Required: exactly 3 push strobes and 3 pop strobes, each 1 cycle wide.
  - Required: blocks_written=blocks_read=3, one done pulse, err=0.
- Consumer stall: num=4, cons_done withheld 50 cycles.
  - Required: after 2 pushes, buf_full_n=0 and prod_start stays 0.
  - Required: prod_start rises 2 cycles after the first pop; the job completes with 4/4.
- Empty job: cfg_num_blocks=0, start pulse.
  - Required: busy high for 2 cycles, one done pulse, prod_start and cons_start never assert.
- Protocol error: inject prod_done while in P_WAIT.
  - Required: err=1 (sticky), no push strobe, blocks_written unchanged.
  - Required: the next accepted start clears err.
- Reset mid-job: assert reset during P_RUN with blocks_written=1.
  - Required: all outputs 0 without waiting for a clock edge.
  - Required: after release, a new num=2 job completes with 2/2.
- Start while busy: pulse start with cfg_num_blocks=7 during a num=2 job.
  - Required: it is ignored; the job ends at 2/2 with a single done pulse.

Source files
------------

// File: rtl/pingpong_stage_ctrl_if.sv
// rtl/pingpong_stage_ctrl_if.sv - handshake bundle between the ping-pong controller and its environment
//
// Purpose: groups the job control, producer/consumer launch handshakes and the
// channel push/pop strobes of one ping-pong channel controller.
// Ports (signals):
//   start, cfg_num_blocks          job request and block count
//   busy, done, err                job status
//   blocks_written, blocks_read    per-job block counters
//   prod_start/prod_done           producer launch handshake
//   cons_start/cons_done           consumer launch handshake
//   buf_full_n, buf_empty_n        channel status
//   buf_i_ce/buf_i_write           push strobe
//   buf_t_ce/buf_t_read            pop strobe
// Modports: master = controller side, slave = environment side.
interface pingpong_stage_ctrl_if #(
  parameter int CntWidth = 16
);
  logic                start;
  logic [CntWidth-1:0] cfg_num_blocks;
  logic                busy;
  logic                done;
  logic                err;
  logic [CntWidth-1:0] blocks_written;
  logic [CntWidth-1:0] blocks_read;
  logic                prod_start;
  logic                prod_done;
  logic                cons_start;
  logic                cons_done;
  logic                buf_full_n;
  logic                buf_empty_n;
  logic                buf_i_ce;
  logic                buf_i_write;
  logic                buf_t_ce;
  logic                buf_t_read;

  modport master (
    input  start, cfg_num_blocks, prod_done, cons_done, buf_full_n, buf_empty_n,
    output busy, done, err, blocks_written, blocks_read, prod_start, cons_start,
           buf_i_ce, buf_i_write, buf_t_ce, buf_t_read
  );

  modport slave (
    output start, cfg_num_blocks, prod_done, cons_done, buf_full_n, buf_empty_n,
    input  busy, done, err, blocks_written, blocks_read, prod_start, cons_start,
           buf_i_ce, buf_i_write, buf_t_ce, buf_t_read
  );
endinterface

// File: rtl/pingpong_stage_ctrl.sv
// rtl/pingpong_stage_ctrl.sv - sequencing controller for one two-buffer ping-pong channel
//
// Purpose: launches the producer whenever the channel has a free buffer and
// commits each filled buffer with a push; launches the consumer whenever a
// filled buffer is available and releases it with a pop; counts a programmed
// number of blocks per job and pulses done at completion.
// Ports:
//   clk    in  clock, all state on rising edge
//   reset  in  asynchronous active-low reset
//   bus    pingpong_stage_ctrl_if.master (job control, launch handshakes,
//          channel status and push/pop strobes)
// All outputs are decoded from registered state only.
module pingpong_stage_ctrl #(
  parameter int CntWidth = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  pingpong_stage_ctrl_if.master   bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} top_state_t;
  typedef enum logic [2:0] {P_IDLE, P_WAIT, P_RUN, P_COMMIT, P_HOLD} prod_state_t;
  typedef enum logic [2:0] {C_IDLE, C_WAIT, C_RUN, C_REL, C_HOLD} cons_state_t;

  top_state_t          r_top, w_top_next;
  prod_state_t         r_prod, w_prod_next;
  cons_state_t         r_cons, w_cons_next;
  logic [CntWidth-1:0] r_num;
  logic [CntWidth-1:0] r_written;
  logic [CntWidth-1:0] r_read;
  logic                r_err;

  logic w_start_acc;
  logic w_more_wr;
  logic w_more_rd;
  logic w_err_evt;

  assign w_start_acc = (r_top == IDLE) && bus.start;
  assign w_more_wr   = (r_written < r_num);
  assign w_more_rd   = (r_read < r_num);

  assign w_err_evt = (bus.prod_done && (r_prod != P_RUN)) ||
                     (bus.cons_done && (r_cons != C_RUN)) ||
                     (!bus.buf_full_n && (r_prod == P_COMMIT)) ||
                     (!bus.buf_empty_n && (r_cons == C_REL));

  // Producer: the hold cycle lets the channel's registered full_n catch up
  // with the push before the next launch decision.
  always_comb begin
    w_prod_next = r_prod;
    case (r_prod)
      P_IDLE:   if (r_top == RUN && w_more_wr) w_prod_next = P_WAIT;
      P_WAIT:   if (bus.buf_full_n) w_prod_next = P_RUN;
      P_RUN:    if (bus.prod_done) w_prod_next = P_COMMIT;
      P_COMMIT: w_prod_next = P_HOLD;
      P_HOLD:   w_prod_next = w_more_wr ? P_WAIT : P_IDLE;
      default:  w_prod_next = P_IDLE;
    endcase
  end

  always_comb begin
    w_cons_next = r_cons;
    case (r_cons)
      C_IDLE:  if (r_top == RUN && w_more_rd) w_cons_next = C_WAIT;
      C_WAIT:  if (bus.buf_empty_n) w_cons_next = C_RUN;
      C_RUN:   if (bus.cons_done) w_cons_next = C_REL;
      C_REL:   w_cons_next = C_HOLD;
      C_HOLD:  w_cons_next = w_more_rd ? C_WAIT : C_IDLE;
      default: w_cons_next = C_IDLE;
    endcase
  end

  // RUN exits on the sub-FSMs' next state so that FIN follows C_HOLD
  // directly instead of waiting an extra cycle for C_IDLE to register.
  always_comb begin
    w_top_next = r_top;
    case (r_top)
      IDLE:    if (bus.start) w_top_next = RUN;
      RUN:     if (r_read == r_num && w_prod_next == P_IDLE && w_cons_next == C_IDLE)
                 w_top_next = FIN;
      FIN:     w_top_next = IDLE;
      default: w_top_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_top     <= IDLE;
      r_prod    <= P_IDLE;
      r_cons    <= C_IDLE;
      r_num     <= '0;
      r_written <= '0;
      r_read    <= '0;
      r_err     <= 1'b0;
    end else begin
      r_top  <= w_top_next;
      r_prod <= w_prod_next;
      r_cons <= w_cons_next;
      if (w_start_acc) begin
        r_num     <= bus.cfg_num_blocks;
        r_written <= '0;
        r_read    <= '0;
      end else begin
        if (r_prod == P_COMMIT) r_written <= r_written + CntWidth'(1);
        if (r_cons == C_REL)    r_read    <= r_read + CntWidth'(1);
      end
      if (w_start_acc) begin
        r_err <= 1'b0;
      end else if (w_err_evt) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.busy           = (r_top != IDLE);
  assign bus.done           = (r_top == FIN);
  assign bus.err            = r_err;
  assign bus.blocks_written = r_written;
  assign bus.blocks_read    = r_read;
  assign bus.prod_start     = (r_prod == P_RUN);
  assign bus.cons_start     = (r_cons == C_RUN);
  assign bus.buf_i_ce       = (r_prod == P_COMMIT);
  assign bus.buf_i_write    = (r_prod == P_COMMIT);
  assign bus.buf_t_ce       = (r_cons == C_REL);
  assign bus.buf_t_read     = (r_cons == C_REL);

endmodule

// File: tb/tb_pingpong_stage_ctrl.sv
// tb/tb_pingpong_stage_ctrl.sv - self-checking bench for pingpong_stage_ctrl
module tb_pingpong_stage_ctrl;
  localparam int CW = 16;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pingpong_stage_ctrl_if #(.CntWidth(CW)) bus ();
  pingpong_stage_ctrl #(.CntWidth(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int cyc, cnt, num, exp_written, exp_read, push_n, pop_n;
  int done_cyc, last_push_cyc, last_pop_cyc;
  bit exp_busy, exp_err, last_exp_push, last_exp_pop, p_stall, c_stall;
  int done_pulses, busy_cycles, ps_cycles, cs_cycles, push_strobes, pop_strobes;
  int p_relaunch, c_relaunch;
  // environment agents
  int p_timer, c_timer, p_lo, p_hi, c_lo, c_hi;
  bit hold_full, inj_pd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic model_clear();
    cnt = 0; num = 0; exp_written = 0; exp_read = 0; push_n = 0; pop_n = 0;
    done_cyc = -10; last_push_cyc = -10; last_pop_cyc = -10;
    exp_busy = 0; exp_err = 0; last_exp_push = 0; last_exp_pop = 0;
    p_stall = 0; c_stall = 0; p_timer = 0; c_timer = 0;
  endtask

  task automatic tick();
    logic pre_ps, pre_pd, pre_cs, pre_cd, pre_push, pre_pop, pre_start, pre_full, pre_empty;
    logic [CW-1:0] pre_cfg;
    bit exp_push, exp_pop, acc;
    pre_ps = bus.prod_start;  pre_pd = bus.prod_done;
    pre_cs = bus.cons_start;  pre_cd = bus.cons_done;
    pre_push = bus.buf_i_ce;  pre_pop = bus.buf_t_ce;
    pre_start = bus.start;    pre_cfg = bus.cfg_num_blocks;
    pre_full = bus.buf_full_n; pre_empty = bus.buf_empty_n;
    @(posedge clk);
    #1;
    cyc++;
    exp_push = 0;
    exp_pop = 0;
    if (!reset) begin
      model_clear();
    end else begin
      cnt = cnt + int'(pre_push) - int'(pre_pop);
      exp_push = pre_ps && pre_pd;
      exp_pop  = pre_cs && pre_cd;
      if ((pre_pd && !pre_ps) || (pre_cd && !pre_cs) ||
          (pre_push && !pre_full) || (pre_pop && !pre_empty)) exp_err = 1;
      exp_written += int'(last_exp_push);
      exp_read    += int'(last_exp_pop);
      acc = pre_start && !exp_busy;
      if (cyc == done_cyc + 1) exp_busy = 0;
      if (acc) begin
        exp_busy = 1; exp_err = 0; num = int'(pre_cfg);
        exp_written = 0; exp_read = 0; push_n = 0; pop_n = 0;
        done_cyc = (num == 0) ? cyc + 1 : -10;
        done_pulses = 0; busy_cycles = 0; ps_cycles = 0; cs_cycles = 0;
        push_strobes = 0; pop_strobes = 0; p_relaunch = 0; c_relaunch = 0;
        p_stall = 0; c_stall = 0;
      end
      if (exp_push) begin push_n++; last_push_cyc = cyc; end
      if (exp_pop) begin
        pop_n++; last_pop_cyc = cyc;
        if (pop_n == num) done_cyc = cyc + 2;
      end
      last_exp_push = exp_push;
      last_exp_pop  = exp_pop;
    end

    chk("busy", bus.busy, exp_busy);
    chk("done", bus.done, (cyc == done_cyc));
    chk("err", bus.err, exp_err);
    chk("blocks_written", bus.blocks_written, exp_written);
    chk("blocks_read", bus.blocks_read, exp_read);
    chk("push_strobe", {bus.buf_i_ce, bus.buf_i_write}, {exp_push, exp_push});
    chk("pop_strobe", {bus.buf_t_ce, bus.buf_t_read}, {exp_pop, exp_pop});
    if (!exp_busy) chk("idle_launch", {bus.prod_start, bus.cons_start}, 2'b00);
    if (bus.prod_start && !pre_ps) begin
      chk("prod_launch_needs_space", pre_full, 1'b1);
      if (p_stall) begin chk("prod_relaunch_after_pop", cyc - last_pop_cyc, 2); p_relaunch++; end
    end
    if (bus.cons_start && !pre_cs && c_stall) begin
      chk("cons_launch_after_push", cyc - last_push_cyc, 2); c_relaunch++;
    end
    if (bus.prod_start) p_stall = 0;
    else if (exp_busy && cnt >= 2 && push_n < num) p_stall = 1;
    if (bus.cons_start) c_stall = 0;
    else if (exp_busy && cnt == 0 && pop_n < num) c_stall = 1;

    done_pulses  += int'(bus.done);
    busy_cycles  += int'(bus.busy);
    ps_cycles    += int'(bus.prod_start);
    cs_cycles    += int'(bus.cons_start);
    push_strobes += int'(bus.buf_i_ce);
    pop_strobes  += int'(bus.buf_t_ce);

    // channel: status flags are registered, so they follow the strobes by one cycle
    bus.buf_full_n  = (cnt < 2) && !hold_full;
    bus.buf_empty_n = (cnt > 0);
    bus.prod_done = 1'b0;
    bus.cons_done = 1'b0;
    if (reset) begin
      if (bus.prod_start) begin
        if (p_timer == 0) p_timer = int'($urandom_range(p_hi, p_lo));
        p_timer--;
        bus.prod_done = (p_timer == 0);
      end else p_timer = 0;
      if (bus.cons_start) begin
        if (c_timer == 0) c_timer = int'($urandom_range(c_hi, c_lo));
        c_timer--;
        bus.cons_done = (c_timer == 0);
      end else c_timer = 0;
      if (inj_pd) bus.prod_done = 1'b1;
    end
  endtask

  task automatic finish_job(input int n, input int budget, input int busy_start_at);
    for (int i = 0; i < budget && exp_busy; i++) begin
      if (i == busy_start_at) begin bus.start = 1'b1; bus.cfg_num_blocks = CW'(7); end
      tick();
      bus.start = 1'b0;
    end
    chk("job_end_busy", bus.busy, 1'b0);
    chk("job_end_written", bus.blocks_written, n);
    chk("job_end_read", bus.blocks_read, n);
    chk("job_done_pulses", done_pulses, 1);
    chk("job_push_strobes", push_strobes, n);
    chk("job_pop_strobes", pop_strobes, n);
    if (n == 0) begin
      chk("empty_busy_cycles", busy_cycles, 2);
      chk("empty_launches", ps_cycles + cs_cycles, 0);
    end
  endtask

  task automatic run_job(input int n, input int budget, input int busy_start_at);
    bus.start = 1'b1;
    bus.cfg_num_blocks = CW'(n);
    tick();
    bus.start = 1'b0;
    bus.cfg_num_blocks = CW'($urandom);
    finish_job(n, budget, busy_start_at);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {bus.busy, bus.done, bus.err, bus.prod_start, bus.cons_start,
              bus.buf_i_ce, bus.buf_i_write, bus.buf_t_ce, bus.buf_t_read}, 9'd0);
    chk({tag, "_cnt"}, {bus.blocks_written, bus.blocks_read}, 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    bus.start = 1'b0; bus.cfg_num_blocks = '0;
    bus.prod_done = 1'b0; bus.cons_done = 1'b0;
    bus.buf_full_n = 1'b1; bus.buf_empty_n = 1'b0;
    hold_full = 0; inj_pd = 0; cyc = 0;
    p_lo = 1; p_hi = 3; c_lo = 1; c_hi = 3;
    model_clear();
    done_pulses = 0; busy_cycles = 0; ps_cycles = 0; cs_cycles = 0;
    push_strobes = 0; pop_strobes = 0; p_relaunch = 0; c_relaunch = 0;
    repeat (3) tick();
    chk_all_zero("reset_state");
    reset = 1'b1;
    tick();

    // nominal job, fixed 4-cycle answers
    p_lo = 4; p_hi = 4; c_lo = 4; c_hi = 4;
    run_job(3, 500, -1);
    chk("nominal_err", bus.err, 1'b0);

    // consumer stall: producer must wait for the first pop
    p_lo = 1; p_hi = 2; c_lo = 50; c_hi = 50;
    run_job(4, 2000, -1);
    chk("stall_relaunch_seen", (p_relaunch > 0), 1'b1);

    // empty job
    run_job(0, 50, -1);

    // protocol error: spurious prod_done while the producer waits for space
    p_lo = 2; p_hi = 3; c_lo = 2; c_hi = 3;
    hold_full = 1;
    bus.buf_full_n = 1'b0;
    bus.start = 1'b1; bus.cfg_num_blocks = CW'(1);
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    inj_pd = 1;
    tick();
    inj_pd = 0;
    tick();
    chk("err_set", bus.err, 1'b1);
    chk("err_no_commit", bus.blocks_written, 0);
    hold_full = 0;
    finish_job(1, 500, -1);
    chk("err_sticky", bus.err, 1'b1);
    run_job(2, 500, -1);
    chk("err_cleared", bus.err, 1'b0);

    // reset mid-job during P_RUN of the second block
    p_lo = 4; p_hi = 6;
    bus.start = 1'b1; bus.cfg_num_blocks = CW'(3);
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 200 && !(exp_written == 1 && bus.prod_start); i++) tick();
    chk("reset_point_reached", {bus.prod_start, bus.blocks_written}, {1'b1, 16'd1});
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("async_reset");
    repeat (2) tick();
    reset = 1'b1;
    tick();
    run_job(2, 500, -1);

    // start while busy is ignored
    run_job(2, 500, 3);

    // randomized jobs
    for (int j = 0; j < 6; j++) begin
      p_lo = int'($urandom_range(3, 1)); p_hi = p_lo + int'($urandom_range(6, 0));
      c_lo = int'($urandom_range(3, 1)); c_hi = c_lo + int'($urandom_range(8, 0));
      run_job(int'($urandom_range(6, 1)), 2000, int'($urandom_range(10, 0)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
